// File: rtl/alpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alpu_pipe_ctrl
// Issue/retire controller for the piped ALPU: shadow valid/tag pipe + result FIFO.
// Rev     : 1.0
// ============================================================================
module alpu_pipe_ctrl #(
   parameter int REG_WIDTH  = 16,
   parameter int TAG_WIDTH  = 4,
   parameter int ALU_STAGES = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             op_valid,
   output logic                             op_ready,
   input  logic [REG_WIDTH-1:0]             op_a,
   input  logic [REG_WIDTH-1:0]             op_b,
   input  logic [7:0]                       op_ctrl,
   input  logic                             op_cin,
   input  logic [TAG_WIDTH-1:0]             op_tag,
   output logic [REG_WIDTH-1:0]             alu_a,
   output logic [REG_WIDTH-1:0]             alu_b,
   output logic [7:0]                       alu_ctrl,
   output logic                             alu_cin,
   output logic                             alu_pipe_active,
   input  logic [REG_WIDTH-1:0]             alu_out,
   input  logic                             alu_cout,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [REG_WIDTH-1:0]             res_data,
   output logic                             res_cout,
   output logic [TAG_WIDTH-1:0]             res_tag,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = REG_WIDTH + 1 + TAG_WIDTH;
   localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(FIFO_DEPTH);

   logic [ALU_STAGES-1:0] v_q, v_d;
   logic [TAG_WIDTH-1:0]  tag_q [ALU_STAGES];
   logic [TAG_WIDTH-1:0]  tag_d [ALU_STAGES];
   logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ENT_W-1:0]      head_q, head_d;

   logic                  w_full, w_pop, w_push, w_advance, w_accept;
   logic [ENT_W-1:0]      w_entry;

   // Handshake and stage-enable decode; reset forces the pipe to hold.
   always_comb begin
      w_full    = (count_q == C_FULL_COUNT);
      w_pop     = (count_q != '0) & res_ready;
      w_advance = ~reset & (~v_q[ALU_STAGES-1] | ~w_full | w_pop);
      w_accept  = op_valid & w_advance;
      w_push    = w_advance & v_q[ALU_STAGES-1];
      w_entry   = {alu_out, alu_cout, tag_q[ALU_STAGES-1]};
   end

   always_comb begin
      v_d   = v_q;
      tag_d = tag_q;
      if (w_advance) begin
         v_d[0]   = w_accept;
         tag_d[0] = op_tag;
         for (int i = 1; i < ALU_STAGES; i++) begin
            v_d[i]   = v_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   // The head register is refilled from the new read slot, or straight from
   // the incoming entry when that entry is the only one left after this cycle.
   always_comb begin
      mem_d = mem_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = w_entry;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
      count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      head_d   = head_q;
      if (count_d != '0) begin
         head_d = (w_push && (wr_ptr_q == rd_ptr_d)) ? w_entry : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q      <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         for (int i = 0; i < ALU_STAGES; i++) begin
            tag_q[i] <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         v_q      <= v_d;
         tag_q    <= tag_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_comb begin
      alu_a           = op_a;
      alu_b           = op_b;
      alu_ctrl        = op_ctrl;
      alu_cin         = op_cin;
      alu_pipe_active = w_advance;
      op_ready        = w_advance;
      res_valid       = (count_q != '0);
      {res_data, res_cout, res_tag} = head_q;
      fifo_count      = count_q;
      busy            = (|v_q) | (count_q != '0);
   end

endmodule
`default_nettype wire

// File: tb/tb_alpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alpu_pipe_ctrl
// Self-checking bench: behavioural ALPU stand-in plus an in-order result queue.
// Rev     : 1.0
// ============================================================================
module tb_alpu_pipe_ctrl;

   localparam int RW = 16;
   localparam int TW = 4;

   logic          clk, reset;
   logic          op_valid, op_ready;
   logic [RW-1:0] op_a, op_b;
   logic [7:0]    op_ctrl;
   logic          op_cin;
   logic [TW-1:0] op_tag;
   logic [RW-1:0] alu_a, alu_b, alu_out;
   logic [7:0]    alu_ctrl;
   logic          alu_cin, alu_pipe_active, alu_cout;
   logic          res_valid, res_ready, res_cout;
   logic [RW-1:0] res_data;
   logic [TW-1:0] res_tag;
   logic          busy;
   logic [2:0]    fifo_count;

   alpu_pipe_ctrl #(.REG_WIDTH(RW), .TAG_WIDTH(TW), .ALU_STAGES(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_ctrl(op_ctrl), .op_cin(op_cin), .op_tag(op_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
      .alu_pipe_active(alu_pipe_active), .alu_out(alu_out), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_cout(res_cout), .res_tag(res_tag), .busy(busy), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADD (8'h2C) is a+b+cin; any other control word is a stand-in XOR.
   function automatic logic [RW:0] ref_alu(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                           input logic [7:0] c, input logic ci);
      if (c == 8'h2C) return {1'b0, a} + {1'b0, b} + {{RW{1'b0}}, ci};
      return {1'b0, a ^ b};
   endfunction

   logic [RW:0] alpu_s [3];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) alpu_s[i] <= '0;
      end else if (alu_pipe_active) begin
         alpu_s[0] <= ref_alu(alu_a, alu_b, alu_ctrl, alu_cin);
         alpu_s[1] <= alpu_s[0];
         alpu_s[2] <= alpu_s[1];
      end
   end
   assign alu_out  = alpu_s[2][RW-1:0];
   assign alu_cout = alpu_s[2][RW];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int first_rv_cyc;
   int n_pops = 0;
   int n_acc = 0;
   logic last_acc, last_pop, last_active;
   logic [RW+TW:0] exp_q [$];
   int pop_cyc [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [RW-1:0] a, input logic [RW-1:0] b,
                              input logic [7:0] c, input logic ci, input logic [TW-1:0] t,
                              input logic rr);
      logic [RW+TW:0] e;
      logic [RW:0]    r;
      op_valid = v; op_a = a; op_b = b; op_ctrl = c; op_cin = ci; op_tag = t;
      res_ready = rr;
      #1;
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("fifo_le_depth", 32'(fifo_count <= 3'd4), 32'd1);
      chk("pass_a", 32'(alu_a), 32'(a));
      chk("pass_ctrl", 32'({alu_ctrl, alu_cin}), 32'({c, ci}));
      chk("ready_eq_active", 32'(op_ready), 32'(alu_pipe_active));
      last_active = alu_pipe_active;
      last_acc    = v & op_ready;
      last_pop    = res_valid & rr;
      if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (last_pop) begin
         pop_cyc.push_back(cyc);
         n_pops++;
         chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e[RW+TW:TW+1]));
            chk("res_cout", 32'(res_cout), 32'(e[TW]));
            chk("res_tag", 32'(res_tag), 32'(e[TW-1:0]));
         end
      end
      if (last_acc) begin
         n_acc++;
         r = ref_alu(a, b, c, ci);
         exp_q.push_back({r[RW-1:0], r[RW], t});
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input logic rr);
      drive_cycle(1'b0, RW'($urandom), RW'($urandom), 8'($urandom), 1'($urandom), TW'($urandom), rr);
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) idle(1'b1);
      chk("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   int t0, p0, a0;

   initial begin
      reset = 1'b1;
      op_valid = 1'b0; op_a = 16'h1234; op_b = '0; op_ctrl = '0; op_cin = 1'b0; op_tag = '0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_head", 32'({res_data, res_cout, res_tag}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_op_ready", 32'(op_ready), 32'd0);
      chk("rst_active", 32'(alu_pipe_active), 32'd0);
      chk("rst_pass_a", 32'(alu_a), 32'h1234);
      @(negedge clk);
      reset = 1'b0;

      // Single ADD: latency and result.
      first_rv_cyc = -1;
      t0 = cyc;
      drive_cycle(1'b1, 16'h0003, 16'h0004, 8'h2C, 1'b0, 4'd5, 1'b1);
      chk("t1_accept", 32'(last_acc), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (res_valid) begin
            chk("t1_data", 32'(res_data), 32'h0007);
            chk("t1_tag", 32'(res_tag), 32'd5);
         end
         idle(1'b1);
         if (last_pop) chk("t1_busy_after_pop", 32'(busy), 32'd0);
      end
      chk("t1_latency", 32'(first_rv_cyc - t0), 32'd4);

      // Back-to-back, tags 0..7, carry on tag 3.
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) drive_cycle(1'b1, 16'hFFFF, 16'h0001, 8'h2C, 1'b0, TW'(i), 1'b1);
         else        drive_cycle(1'b1, RW'($urandom), RW'($urandom), 8'h2C, 1'($urandom), TW'(i), 1'b1);
         chk("t2_no_stall", 32'(last_acc), 32'd1);
      end
      drain(20);
      chk("t2_pop_count", 32'(pop_cyc.size()), 32'd8);
      for (int i = 1; i < pop_cyc.size(); i++)
         chk("t2_one_per_cycle", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

      // Backpressure: 10 ops with res_ready low, then full push+pop.
      a0 = n_acc;
      for (int i = 0; i < 10; i++)
         drive_cycle(1'b1, RW'($urandom), RW'($urandom), 8'h2C, 1'($urandom), TW'(i), 1'b0);
      chk("t3_accepted", 32'(n_acc - a0), 32'd7);
      chk("t3_fifo_full", 32'(fifo_count), 32'd4);
      chk("t3_op_ready_low", 32'(op_ready), 32'd0);
      chk("t3_active_low", 32'(alu_pipe_active), 32'd0);
      p0 = n_pops;
      idle(1'b1);
      chk("t4_active_on_pop", 32'(last_active), 32'd1);
      chk("t4_count_held", 32'(fifo_count), 32'd4);
      drain(30);
      chk("t3_drained", 32'(n_pops - p0), 32'd7);

      // Sparse ops, toggling res_ready.
      for (int i = 0; i < 60; i++)
         drive_cycle(i % 3 == 0, RW'($urandom), RW'($urandom),
                     ($urandom_range(0, 1) != 0) ? 8'h2C : 8'($urandom),
                     1'($urandom), TW'($urandom), 1'(i % 2 == 0));
      drain(30);

      // Fully random traffic.
      for (int i = 0; i < 300; i++)
         drive_cycle(1'($urandom), RW'($urandom), RW'($urandom),
                     ($urandom_range(0, 1) != 0) ? 8'h2C : 8'($urandom),
                     1'($urandom), TW'($urandom), 1'($urandom_range(0, 3) != 0));
      drain(40);

      // Reset with 2 in shadow and 2 in FIFO.
      drive_cycle(1'b1, 16'h0101, 16'h0202, 8'h2C, 1'b0, 4'd1, 1'b0);
      drive_cycle(1'b1, 16'h0303, 16'h0404, 8'h2C, 1'b0, 4'd2, 1'b0);
      idle(1'b0);
      drive_cycle(1'b1, 16'h0505, 16'h0606, 8'h2C, 1'b0, 4'd3, 1'b0);
      drive_cycle(1'b1, 16'h0707, 16'h0808, 8'h2C, 1'b0, 4'd4, 1'b0);
      #1;
      chk("t6_pre_count", 32'(fifo_count), 32'd2);
      chk("t6_pre_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t6_res_valid", 32'(res_valid), 32'd0);
      chk("t6_fifo_count", 32'(fifo_count), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_op_ready", 32'(op_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      p0 = n_pops;
      first_rv_cyc = -1;
      t0 = cyc;
      drive_cycle(1'b1, 16'h0010, 16'h0020, 8'h2C, 1'b1, 4'd9, 1'b1);
      chk("t6_accept", 32'(last_acc), 32'd1);
      for (int i = 0; i < 10; i++) idle(1'b1);
      chk("t6_latency", 32'(first_rv_cyc - t0), 32'd4);
      chk("t6_one_result", 32'(n_pops - p0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
